// File: rtl/fractal_lane_engine.sv
`default_nettype none
// ============================================================================
// Module   : fractal_lane_engine
// Purpose  : Multi-lane escape-time fractal pixel engine. Sweeps an
//            X_SIZE x Y_SIZE raster and hands pixels round-robin to LANES
//            fixed-point iterators (Mandelbrot or Julia, chosen per frame).
//            Iteration counts come out strictly in raster order over a
//            valid/ready handshake.
// Ports    : out_stream_aclk / periph_resetn : clock, async active-low reset
//            cfg_*                           : frame config, sampled at (0,0)
//            out_iter/out_x/out_y            : result beat payload
//            out_sof/out_eol                 : frame / line markers
//            out_valid/out_ready             : output handshake
// Revision : 1.0 - initial release
// ============================================================================
module fractal_lane_engine #(
  parameter int LANES     = 4,
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 8,
  parameter int ITER_W    = 8,
  parameter int X_SIZE    = 640,
  parameter int Y_SIZE    = 480
) (
  input  logic                     out_stream_aclk,
  input  logic                     periph_resetn,
  input  logic                     cfg_mode,
  input  logic [ITER_W-1:0]        cfg_max_iter,
  input  logic signed [DATA_W-1:0] cfg_c_re,
  input  logic signed [DATA_W-1:0] cfg_c_im,
  input  logic signed [DATA_W-1:0] cfg_offset_re,
  input  logic signed [DATA_W-1:0] cfg_offset_im,
  input  logic signed [DATA_W-1:0] cfg_step_re,
  input  logic signed [DATA_W-1:0] cfg_step_im,
  output logic [ITER_W-1:0]        out_iter,
  output logic [9:0]               out_x,
  output logic [8:0]               out_y,
  output logic                     out_sof,
  output logic                     out_eol,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int                      C_PTR_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [C_PTR_W-1:0]      C_LAST_PTR = C_PTR_W'(LANES - 1);
  localparam logic [9:0]              C_X_LAST   = 10'(X_SIZE - 1);
  localparam logic [8:0]              C_Y_LAST   = 9'(Y_SIZE - 1);
  localparam logic signed [DATA_W:0]  C_ESC_LIM  = (DATA_W + 1)'(4 << FRAC_BITS);

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_ITER = 2'd1,
    L_DONE = 2'd2
  } lane_state_e;

  // --------------------------------------------------------------------------
  // Dispatcher state and frame shadow config
  // --------------------------------------------------------------------------
  logic [C_PTR_W-1:0]        d_ptr_q;
  logic [9:0]                dx_q;
  logic [8:0]                dy_q;
  logic signed [DATA_W-1:0]  cre_q, cim_q;
  logic                      sh_mode_q;
  logic [ITER_W-1:0]         sh_max_q;
  logic signed [DATA_W-1:0]  sh_c_re_q, sh_c_im_q, sh_off_re_q, sh_off_im_q;
  logic signed [DATA_W-1:0]  sh_step_re_q, sh_step_im_q;

  // Per-lane status and payload, gathered from the lane generate block
  logic [LANES-1:0]          w_idle;
  logic [LANES-1:0]          w_done;
  logic [ITER_W-1:0]         w_res  [LANES];
  logic [9:0]                w_px   [LANES];
  logic [8:0]                w_py   [LANES];
  logic [LANES-1:0]          w_psof;
  logic [LANES-1:0]          w_peol;

  logic                      w_first;
  logic                      w_disp;
  logic                      w_mode;
  logic [ITER_W-1:0]         w_max;
  logic signed [DATA_W-1:0]  w_c_re, w_c_im, w_pix_re, w_pix_im;
  logic signed [DATA_W-1:0]  w_off_re, w_step_re, w_step_im;

  // Pixel (0,0) uses the live cfg_* inputs because the shadows only capture
  // them on that very edge; every later pixel in the frame uses the shadows.
  assign w_first   = (dx_q == '0) && (dy_q == '0);
  assign w_mode    = w_first ? cfg_mode      : sh_mode_q;
  assign w_max     = w_first ? cfg_max_iter  : sh_max_q;
  assign w_c_re    = w_first ? cfg_c_re      : sh_c_re_q;
  assign w_c_im    = w_first ? cfg_c_im      : sh_c_im_q;
  assign w_off_re  = w_first ? cfg_offset_re : sh_off_re_q;
  assign w_step_re = w_first ? cfg_step_re   : sh_step_re_q;
  assign w_step_im = w_first ? cfg_step_im   : sh_step_im_q;
  assign w_pix_re  = w_first ? cfg_offset_re : cre_q;
  assign w_pix_im  = w_first ? cfg_offset_im : cim_q;

  assign w_disp    = w_idle[d_ptr_q];

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      d_ptr_q      <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      cre_q        <= '0;
      cim_q        <= '0;
      sh_mode_q    <= 1'b0;
      sh_max_q     <= '0;
      sh_c_re_q    <= '0;
      sh_c_im_q    <= '0;
      sh_off_re_q  <= '0;
      sh_off_im_q  <= '0;
      sh_step_re_q <= '0;
      sh_step_im_q <= '0;
    end else if (w_disp) begin
      d_ptr_q <= (d_ptr_q == C_LAST_PTR) ? '0 : d_ptr_q + 1'b1;
      if (w_first) begin
        sh_mode_q    <= cfg_mode;
        sh_max_q     <= cfg_max_iter;
        sh_c_re_q    <= cfg_c_re;
        sh_c_im_q    <= cfg_c_im;
        sh_off_re_q  <= cfg_offset_re;
        sh_off_im_q  <= cfg_offset_im;
        sh_step_re_q <= cfg_step_re;
        sh_step_im_q <= cfg_step_im;
      end
      if (dx_q == C_X_LAST) begin
        dx_q  <= '0;
        cre_q <= w_off_re;
        cim_q <= w_pix_im + w_step_im;
        dy_q  <= (dy_q == C_Y_LAST) ? '0 : dy_q + 1'b1;
      end else begin
        dx_q  <= dx_q + 1'b1;
        cre_q <= w_pix_re + w_step_re;
        cim_q <= w_pix_im;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Collector / output register
  // --------------------------------------------------------------------------
  logic [C_PTR_W-1:0] c_ptr_q;
  logic               out_valid_q, out_sof_q, out_eol_q;
  logic [ITER_W-1:0]  out_iter_q;
  logic [9:0]         out_x_q;
  logic [8:0]         out_y_q;
  logic               w_load;

  assign w_load = w_done[c_ptr_q] & (~out_valid_q | out_ready);

  // --------------------------------------------------------------------------
  // Iterator lanes
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam logic [C_PTR_W-1:0] C_IDX = C_PTR_W'(k);

    lane_state_e                state_q;
    logic signed [DATA_W-1:0]   zr_q, zi_q, cr_q, ci_q;
    logic [ITER_W-1:0]          max_q, n_q;
    logic [9:0]                 x_q;
    logic [8:0]                 y_q;
    logic                       sof_q, eol_q;

    logic                       w_ld, w_take, w_esc;
    logic signed [2*DATA_W-1:0] w_prr, w_pii, w_pri;
    logic signed [2*DATA_W:0]   w_pri2;
    logic signed [DATA_W-1:0]   w_zr2, w_zi2, w_zx;
    logic signed [DATA_W:0]     w_mag;

    assign w_ld   = w_disp & (d_ptr_q == C_IDX);
    assign w_take = w_load & (c_ptr_q == C_IDX);

    // Full-width products, arithmetic shift, then truncate back to DATA_W.
    assign w_prr  = (2*DATA_W)'(zr_q) * (2*DATA_W)'(zr_q);
    assign w_pii  = (2*DATA_W)'(zi_q) * (2*DATA_W)'(zi_q);
    assign w_pri  = (2*DATA_W)'(zr_q) * (2*DATA_W)'(zi_q);
    assign w_pri2 = {w_pri, 1'b0};
    assign w_zr2  = DATA_W'(w_prr >>> FRAC_BITS);
    assign w_zi2  = DATA_W'(w_pii >>> FRAC_BITS);
    assign w_zx   = DATA_W'(w_pri2 >>> FRAC_BITS);
    // One extra bit so the magnitude sum itself cannot wrap past the limit.
    assign w_mag  = {w_zr2[DATA_W-1], w_zr2} + {w_zi2[DATA_W-1], w_zi2};
    assign w_esc  = (w_mag > C_ESC_LIM);

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
      if (!periph_resetn) begin
        state_q <= L_IDLE;
        zr_q    <= '0;
        zi_q    <= '0;
        cr_q    <= '0;
        ci_q    <= '0;
        max_q   <= '0;
        n_q     <= '0;
        x_q     <= '0;
        y_q     <= '0;
        sof_q   <= 1'b0;
        eol_q   <= 1'b0;
      end else begin
        case (state_q)
          L_IDLE: begin
            if (w_ld) begin
              state_q <= L_ITER;
              zr_q    <= w_mode ? w_pix_re : '0;
              zi_q    <= w_mode ? w_pix_im : '0;
              cr_q    <= w_mode ? w_c_re   : w_pix_re;
              ci_q    <= w_mode ? w_c_im   : w_pix_im;
              max_q   <= w_max;
              n_q     <= '0;
              x_q     <= dx_q;
              y_q     <= dy_q;
              sof_q   <= w_first;
              eol_q   <= (dx_q == C_X_LAST);
            end
          end
          L_ITER: begin
            if (w_esc || (n_q == max_q)) begin
              state_q <= L_DONE;
            end else begin
              zr_q <= w_zr2 - w_zi2 + cr_q;
              zi_q <= w_zx + ci_q;
              n_q  <= n_q + 1'b1;
            end
          end
          L_DONE: begin
            if (w_take) begin
              state_q <= L_IDLE;
            end
          end
          default: state_q <= L_IDLE;
        endcase
      end
    end

    assign w_idle[k] = (state_q == L_IDLE);
    assign w_done[k] = (state_q == L_DONE);
    assign w_res[k]  = n_q;
    assign w_px[k]   = x_q;
    assign w_py[k]   = y_q;
    assign w_psof[k] = sof_q;
    assign w_peol[k] = eol_q;
  end

  // The collector pointer follows dispatch order, so beats leave in raster
  // order regardless of how long each lane iterates.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      c_ptr_q     <= '0;
      out_valid_q <= 1'b0;
      out_iter_q  <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
    end else if (w_load) begin
      c_ptr_q     <= (c_ptr_q == C_LAST_PTR) ? '0 : c_ptr_q + 1'b1;
      out_valid_q <= 1'b1;
      out_iter_q  <= w_res[c_ptr_q];
      out_x_q     <= w_px[c_ptr_q];
      out_y_q     <= w_py[c_ptr_q];
      out_sof_q   <= w_psof[c_ptr_q];
      out_eol_q   <= w_peol[c_ptr_q];
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_iter  = out_iter_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_sof   = out_sof_q;
  assign out_eol   = out_eol_q;

endmodule
`default_nettype wire
